// File: rtl/regfile_pkg.sv
// Shared widths and types for the scoreboarded register file.
package regfile_pkg;

   localparam int DATA_W_DEF   = 48;
   localparam int ADDR_W_DEF   = 2;
   localparam int NUM_REGS_DEF = 2 ** ADDR_W_DEF;

   typedef logic [DATA_W_DEF-1:0]   reg_data_t;
   typedef logic [ADDR_W_DEF-1:0]   reg_adr_t;
   typedef logic [NUM_REGS_DEF-1:0] pending_vec_t;

endpackage

// File: rtl/regfile_pending_table.sv
// Scoreboard: one pending bit per register, set by accepted reservations and cleared by writeback.
// Honours REGFILE_ZERO_REG_EN (register 0 never pending).
import regfile_pkg::*;

module regfile_pending_table #(
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int NUM_REGS = 2 ** ADDR_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                write_en,
   input  logic [ADDR_W-1:0]   write_adr,
   input  logic                rsv_en,
   input  logic [ADDR_W-1:0]   rsv_adr,
   output logic                rsv_ok,
   output logic [NUM_REGS-1:0] pending
);

   logic [NUM_REGS-1:0] pending_q;
   logic [NUM_REGS-1:0] pending_d;

   // A same-cycle writeback to the reserved register frees it in time for the new reservation.
   always_comb begin
      rsv_ok    = rsv_en & (~pending_q[rsv_adr] | (write_en & (write_adr == rsv_adr)));
      pending_d = pending_q;
      if (write_en) begin
         pending_d[write_adr] = 1'b0;
      end
      if (rsv_ok) begin
         pending_d[rsv_adr] = 1'b1;
      end
`ifdef REGFILE_ZERO_REG_EN
      pending_d[0] = 1'b0;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pending_q <= '0;
      end else begin
         pending_q <= pending_d;
      end
   end

   assign pending = pending_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Parametrised 2-read/1-write register file with write-to-read bypass and pending scoreboard.
// Optional: define REGFILE_ZERO_REG_EN to hardwire register 0 to zero.
import regfile_pkg::*;

module regfile_scoreboard #(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int NUM_REGS = 2 ** ADDR_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [ADDR_W-1:0]   read_adr_a,
   input  logic [ADDR_W-1:0]   read_adr_b,
   output logic [DATA_W-1:0]   reg_a,
   output logic [DATA_W-1:0]   reg_b,
   output logic                a_ready,
   output logic                b_ready,
   input  logic                write_en,
   input  logic [ADDR_W-1:0]   write_adr,
   input  logic [DATA_W-1:0]   write_data,
   input  logic                rsv_en,
   input  logic [ADDR_W-1:0]   rsv_adr,
   output logic                rsv_ok,
   output logic [NUM_REGS-1:0] pending
);

   logic [DATA_W-1:0] mem_q [NUM_REGS];
   logic              writeEff;

   // Writes to the hardwired zero register are dropped before they reach storage, bypass or scoreboard.
`ifdef REGFILE_ZERO_REG_EN
   assign writeEff = write_en & (write_adr != '0);
`else
   assign writeEff = write_en;
`endif

   regfile_pending_table #(
      .ADDR_W   (ADDR_W),
      .NUM_REGS (NUM_REGS)
   ) u_pending (
      .clk       (clk),
      .rst       (rst),
      .write_en  (writeEff),
      .write_adr (write_adr),
      .rsv_en    (rsv_en),
      .rsv_adr   (rsv_adr),
      .rsv_ok    (rsv_ok),
      .pending   (pending)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            mem_q[i] <= '0;
         end
      end else if (writeEff) begin
         mem_q[write_adr] <= write_data;
      end
   end

   // A register being written this cycle is forwarded and counts as ready regardless of its pending bit.
   always_comb begin
      reg_a   = mem_q[read_adr_a];
      a_ready = ~pending[read_adr_a];
      if (writeEff && (write_adr == read_adr_a)) begin
         reg_a   = write_data;
         a_ready = 1'b1;
      end
   end

   always_comb begin
      reg_b   = mem_q[read_adr_b];
      b_ready = ~pending[read_adr_b];
      if (writeEff && (write_adr == read_adr_b)) begin
         reg_b   = write_data;
         b_ready = 1'b1;
      end
   end

endmodule
